// File: rtl/decryption_cfg_regfile_pkg.sv
// Register map constants and bit positions shared by the decryption config register file.
// Latency: n/a (constants only).
// Backpressure: n/a.
package decryption_regfile_pkg;

    // Width of the live portion of the SELECT register
    localparam int SEL_W = 2;

    // Fixed register addresses (key slots are parameterised in the top level)
    localparam logic [7:0] SELECT_ADDR = 8'h00;
    localparam logic [7:0] CTRL_ADDR   = 8'h20;
    localparam logic [7:0] STATUS_ADDR = 8'h22;

    // CTRL write bits
    localparam int CTRL_COMMIT_BIT = 0;
    localparam int CTRL_LOCK_BIT   = 1;

    // STATUS read bits
    localparam int STAT_PENDING_BIT = 0;
    localparam int STAT_LOCKED_BIT  = 1;
    localparam int STAT_BUSY_BIT    = 2;

endpackage

// File: rtl/decryption_cfg_regfile_if.sv
// Register bus between a configuration master and the decryption register file.
// Latency: access presented in one cycle, done/error/rdata returned the cycle after.
// Backpressure: none; every access completes in exactly one cycle.
interface decryption_cfg_regfile_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int REG_WIDTH  = 16
);
    logic [ADDR_WIDTH-1:0] addr;
    logic                  read;
    logic                  write;
    logic [REG_WIDTH-1:0]  wdata;
    logic [REG_WIDTH-1:0]  rdata;
    logic                  done;
    logic                  error;

    modport master (
        output addr, read, write, wdata,
        input  rdata, done, error
    );

    modport slave (
        input  addr, read, write, wdata,
        output rdata, done, error
    );
endinterface

// File: rtl/decryption_key_slot.sv
// One key slot: shadow register written by the bus, active register copied from it on commit.
// Latency: shadow updates at the write edge; active updates at the commit edge.
// Backpressure: none; the caller withholds commit while the engines are busy.
module decryption_key_slot #(
    parameter int                   REG_WIDTH = 16,
    parameter logic [REG_WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [REG_WIDTH-1:0] wdata,
    input  logic                 commit,
    output logic [REG_WIDTH-1:0] shadow,
    output logic [REG_WIDTH-1:0] active
);

    // Shadow takes bus writes; active samples the pre-write shadow on commit
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= RESET_VAL;
            active <= RESET_VAL;
        end else begin
            if (wr_en) begin
                shadow <= wdata;
            end
            if (commit) begin
                active <= shadow;
            end
        end
    end

endmodule

// File: rtl/decryption_cfg_regfile.sv
// Config register file for the decryption datapath: SELECT, double-buffered keys, CTRL, STATUS.
// Latency: every access answered with a one-cycle done (plus error if rejected) the cycle after.
// Backpressure: none on the bus; key commits wait while engine_busy is high.
module decryption_cfg_regfile
    import decryption_regfile_pkg::*;
#(
    parameter int                            ADDR_WIDTH = 8,
    parameter int                            REG_WIDTH  = 16,
    parameter int                            NUM_KEYS   = 3,
    parameter logic [ADDR_WIDTH-1:0]         KEY_BASE   = 8'h10,
    parameter int                            KEY_STRIDE = 2,
    parameter logic [NUM_KEYS*REG_WIDTH-1:0] KEY_RESET  = {16'h0002, 16'hFFFF, 16'h0000}
) (
    input  logic                          clk,
    input  logic                          rst,
    decryption_cfg_regfile_if.slave       bus,
    input  logic                          engine_busy,
    output logic [REG_WIDTH-1:0]          select,
    output logic [NUM_KEYS*REG_WIDTH-1:0] keys
);

    logic [SEL_W-1:0]     sel_q;
    logic                 pending_q;
    logic                 locked_q;
    logic                 done_q;
    logic                 error_q;
    logic [REG_WIDTH-1:0] rdata_q;

    logic [NUM_KEYS-1:0]  key_hit;
    logic [REG_WIDTH-1:0] key_shadow [NUM_KEYS];

    logic                 hit_sel;
    logic                 hit_ctrl;
    logic                 hit_stat;
    logic                 hit_key;
    logic                 access;
    logic                 acc_err;
    logic                 wr_ok;
    logic                 rd_ok;
    logic                 commit_fire;
    logic [REG_WIDTH-1:0] rd_mux;

    // Key slots: each decodes its own address and shares the commit strobe
    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_slot
        localparam logic [ADDR_WIDTH-1:0] SLOT_ADDR = ADDR_WIDTH'(KEY_BASE + g * KEY_STRIDE);

        assign key_hit[g] = (bus.addr == SLOT_ADDR);

        decryption_key_slot #(
            .REG_WIDTH (REG_WIDTH),
            .RESET_VAL (KEY_RESET[g*REG_WIDTH +: REG_WIDTH])
        ) u_slot (
            .clk    (clk),
            .rst    (rst),
            .wr_en  (wr_ok & key_hit[g]),
            .wdata  (bus.wdata),
            .commit (commit_fire),
            .shadow (key_shadow[g]),
            .active (keys[g*REG_WIDTH +: REG_WIDTH])
        );
    end

    // Address decode and rejection rules; a rejected access has no side effect
    always_comb begin
        hit_sel     = (bus.addr == ADDR_WIDTH'(SELECT_ADDR));
        hit_ctrl    = (bus.addr == ADDR_WIDTH'(CTRL_ADDR));
        hit_stat    = (bus.addr == ADDR_WIDTH'(STATUS_ADDR));
        hit_key     = |key_hit;
        access      = bus.read | bus.write;
        acc_err     = access & (
                          ~(hit_sel | hit_ctrl | hit_stat | hit_key)
                        | (bus.read & bus.write)
                        | (bus.write & hit_stat)
                        | (bus.write & locked_q & (hit_sel | hit_key)));
        wr_ok       = bus.write & ~acc_err;
        rd_ok       = bus.read & ~acc_err;
        commit_fire = pending_q & ~engine_busy;
    end

    // Read data mux; CTRL and unused SELECT bits read as zero
    always_comb begin
        rd_mux = '0;
        if (hit_sel) begin
            rd_mux[SEL_W-1:0] = sel_q;
        end
        if (hit_stat) begin
            rd_mux[STAT_PENDING_BIT] = pending_q;
            rd_mux[STAT_LOCKED_BIT]  = locked_q;
            rd_mux[STAT_BUSY_BIT]    = engine_busy;
        end
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (key_hit[i]) begin
                rd_mux = key_shadow[i];
            end
        end
    end

    // SELECT is not shadowed; accepted writes take effect immediately
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q <= '0;
        end else if (wr_ok && hit_sel) begin
            sel_q <= bus.wdata[SEL_W-1:0];
        end
    end

    // Pending: set by COMMIT, cleared when the keys transfer; a new COMMIT wins over the clear
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= 1'b0;
        end else if (wr_ok && hit_ctrl && bus.wdata[CTRL_COMMIT_BIT]) begin
            pending_q <= 1'b1;
        end else if (commit_fire) begin
            pending_q <= 1'b0;
        end
    end

    // Lock is sticky until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            locked_q <= 1'b0;
        end else if (wr_ok && hit_ctrl && bus.wdata[CTRL_LOCK_BIT]) begin
            locked_q <= 1'b1;
        end
    end

    // Access response: one-cycle done/error; rdata refreshed only by reads, zero when rejected
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            done_q  <= access;
            error_q <= acc_err;
            if (bus.read) begin
                rdata_q <= rd_ok ? rd_mux : '0;
            end
        end
    end

    assign bus.done  = done_q;
    assign bus.error = error_q;
    assign bus.rdata = rdata_q;
    assign select    = {{(REG_WIDTH-SEL_W){1'b0}}, sel_q};

endmodule
